// File: rtl/fetch_pkg.sv
// fetch_pkg: fetch FSM states and cache address-field width helpers
package fetch_pkg;
  typedef enum logic [1:0] {RUN, MISS, FILL} state_t;
  function automatic int offset_w(input int words);
    return 2 + $clog2(words);
  endfunction
  function automatic int index_w(input int lines);
    return $clog2(lines);
  endfunction
  function automatic int tag_w(input int addr_w, input int lines, input int words);
    return addr_w - offset_w(words) - index_w(lines);
  endfunction
endpackage

// File: rtl/icache_dm_array.sv
// icache_dm_array: direct-mapped tag/valid/data storage, one write port, one combinational read port
module icache_dm_array
  import fetch_pkg::*;
#(
  parameter int LINES = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W = 24
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             we,
  input  logic [index_w(LINES)-1:0]        widx,
  input  logic [TAG_W-1:0]                 wtag,
  input  logic [WORDS_PER_LINE-1:0][31:0]  wdata,
  input  logic [index_w(LINES)-1:0]        ridx,
  output logic                             rvalid,
  output logic [TAG_W-1:0]                 rtag,
  output logic [WORDS_PER_LINE-1:0][31:0]  rdata
);
  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [WORDS_PER_LINE-1:0][31:0] data_q [LINES];
  always_comb begin
    valid_d = rst ? '0 : we ? valid_q | (LINES'(1) << widx) : valid_q;
    rvalid = valid_q[ridx];
    rtag = tag_q[ridx];
    rdata = data_q[ridx];
  end
  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    if (we && !rst) begin
      tag_q[widx] <= wtag;
      data_q[widx] <= wdata;
    end
  end
endmodule

// File: rtl/fetch_cache_unit.sv
// fetch_cache_unit: PC register, RUN/MISS/FILL refill FSM and miss counter around a direct-mapped I-cache
module fetch_cache_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINES = 16,
  parameter int WORDS_PER_LINE = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                            Clk,
  input  logic                            Rst,
  input  logic                            PCSrc,
  input  logic [ADDR_W-1:0]               branchTarget,
  input  logic                            stall,
  output logic [31:0]                     inst,
  output logic [ADDR_W-1:0]               pcOut,
  output logic                            instValid,
  output logic                            hit,
  output logic                            memReq,
  output logic [ADDR_W-1:0]               memAddr,
  input  logic                            memAck,
  input  logic [32*WORDS_PER_LINE-1:0]    memData,
  output logic [15:0]                     missCount
);
  localparam int OFFSET_W = offset_w(WORDS_PER_LINE);
  localparam int INDEX_W = index_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES, WORDS_PER_LINE);
  localparam int WSEL_W = WORDS_PER_LINE > 1 ? $clog2(WORDS_PER_LINE) : 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFFSET_W) - 1);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, miss_addr_q, miss_addr_d;
  logic [15:0] miss_cnt_q, miss_cnt_d;
  logic rd_valid, lookup_hit, fill;
  logic [TAG_W-1:0] rd_tag;
  logic [WORDS_PER_LINE-1:0][31:0] rd_line;
  logic [WSEL_W-1:0] wsel;
  icache_dm_array #(
    .LINES(LINES),
    .WORDS_PER_LINE(WORDS_PER_LINE),
    .TAG_W(TAG_W)
  ) u_array (
    .clk(Clk),
    .rst(Rst),
    .we(fill),
    .widx(miss_addr_q[OFFSET_W +: INDEX_W]),
    .wtag(miss_addr_q[ADDR_W-1 -: TAG_W]),
    .wdata(memData),
    .ridx(pc_q[OFFSET_W +: INDEX_W]),
    .rvalid(rd_valid),
    .rtag(rd_tag),
    .rdata(rd_line)
  );
  // The refill address is latched at miss time so a redirect in MISS cannot disturb it
  always_comb begin
    wsel = WSEL_W'((pc_q >> 2) & ADDR_W'(WORDS_PER_LINE - 1));
    lookup_hit = state_q == RUN && rd_valid && rd_tag == pc_q[ADDR_W-1 -: TAG_W];
    fill = state_q == MISS && memAck;
    hit = lookup_hit && !Rst;
    instValid = hit;
    inst = hit ? rd_line[wsel] : '0;
    pcOut = pc_q + ADDR_W'(4);
    memReq = state_q == MISS && !Rst;
    memAddr = miss_addr_q;
    missCount = miss_cnt_q;
    miss_cnt_d = fill ? miss_cnt_q + 16'd1 : miss_cnt_q;
    miss_addr_d = state_q == RUN && !lookup_hit ? pc_q & ~OFF_MASK : miss_addr_q;
    state_d = state_q == RUN ? ((lookup_hit || PCSrc) ? RUN : MISS) :
              state_q == MISS ? (memAck ? FILL : MISS) : RUN;
    pc_d = PCSrc ? branchTarget & ~ADDR_W'(3) : (lookup_hit && !stall) ? pcOut : pc_q;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= RUN;
      pc_q <= RESET_PC;
      miss_cnt_q <= '0;
      miss_addr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      miss_cnt_q <= miss_cnt_d;
      miss_addr_q <= miss_addr_d;
    end
  end
endmodule

// File: doc/fetch_cache_unit.md
FETCH_CACHE_UNIT -- requirements
Module: fetch_cache_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and byte-address width.
REQ-002 SHALL have parameter LINES, default 16, number of direct-mapped cache lines (power of 2, >=2).
REQ-003 SHALL have parameter WORDS_PER_LINE, default 4, 32-bit words per line (power of 2, >=1).
REQ-004 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-005 SHALL have port Clk  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port Rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port PCSrc  input  1  redirect request; load branchTarget into PC.
REQ-008 SHALL have port branchTarget  input  ADDR_W  redirect address.
REQ-009 SHALL have port stall  input  1  downstream stall; hold PC on a hit.
REQ-010 SHALL have port inst  output  32  fetched instruction, 0 (NOP) when instValid=0.
REQ-011 SHALL have port pcOut  output  ADDR_W  PC+4 of the current PC.
REQ-012 SHALL have port instValid  output  1  inst is a valid hit this cycle.
REQ-013 SHALL have port hit  output  1  current PC hits the cache (RUN state only).
REQ-014 SHALL have port memReq  output  1  line-refill request to instruction memory.
REQ-015 SHALL have port memAddr  output  ADDR_W  line-aligned refill address.
REQ-016 SHALL have port memAck  input  1  refill data valid, one-cycle pulse.
REQ-017 SHALL have port memData  input  32*WORDS_PER_LINE  refill line, word 0 in bits [31:0].
REQ-018 SHALL have port missCount  output  16  refill counter, wraps modulo 2^16.

Function
REQ-019 SHALL split the PC into offset (low 2+log2(WORDS_PER_LINE) bits), index (log2(LINES) bits) and tag (remainder).
REQ-020 SHALL compute hit combinationally from the registered PC: valid[index] and tag match, only in state RUN.
REQ-021 SHALL implement the states RUN, MISS and FILL.
REQ-022 In RUN with hit: instValid=1, inst=selected word; PC<=PC+4 unless stall=1.
REQ-023 In RUN without hit and PCSrc=0: next state MISS; PC held.
REQ-024 In MISS: memReq=1, memAddr=PC with offset bits zeroed, both held stable until memAck=1.
REQ-025 On the edge where memAck=1 in MISS: write memData, tag and valid into line index, increment missCount, next state FILL.
REQ-026 FILL SHALL last exactly one cycle, memReq=0, instValid=0, then RUN.
REQ-027 PCSrc=1 SHALL load branchTarget with bits [1:0] forced to 0 in any state, with priority over stall and over PC+4.
REQ-028 PCSrc=1 during MISS SHALL NOT abort the request; refill completes for the original memAddr, then RUN looks up the new PC.
REQ-029 memAck outside MISS SHALL be ignored.
REQ-030 PC+4 SHALL wrap modulo 2^ADDR_W; pcOut likewise.
REQ-031 Hit latency SHALL be 0 cycles from PC register; miss penalty SHALL be (ack latency)+2 cycles.

Reset
REQ-032 With Rst=1 at an edge: PC<=RESET_PC, state<=RUN, all valid bits<=0, missCount<=0; takes priority over all other inputs, including mid-refill.
REQ-033 During and after reset until the first fill: instValid=0, hit=0, inst=0, memReq=0 in the reset cycle, pcOut=RESET_PC+4.
REQ-034 Data and tag arrays SHALL NOT require reset.

Structure
REQ-035 Shared package fetch_pkg SHALL hold the state enum and width helpers (OFFSET_W, INDEX_W, TAG_W as functions of the parameters).
REQ-036 Storage SHALL be a sub-module icache_dm_array (tag/valid/data arrays, one write port, one combinational read port); FSM, PC and counter stay in fetch_cache_unit.

Verification
REQ-037 Reset, PC=0, memAck after 3 cycles with line {4,3,2,1} -> memReq/memAddr=0 held 3 cycles, FILL, then inst=1,2,3,4 on consecutive cycles, missCount=1.
REQ-038 Hit with stall=1 for 2 cycles at PC=0x4 -> inst=2 held, pcOut=0x8 held, no memReq.
REQ-039 PCSrc=1, branchTarget=0x43 during MISS for 0x10 -> refill of line 0x10 completes, then lookup at 0x40 misses, memAddr=0x40.
REQ-040 Fill index 0 with tag A, then PC aliasing index 0 with tag B -> miss, line replaced, return to tag A misses again, missCount=3.
REQ-041 Rst=1 in MISS with memAck=1 same edge -> no line written, valid all 0, state RUN, PC=RESET_PC.
REQ-042 PC=0xFFFFFFFC hitting -> pcOut=0x0, next PC=0x0.
